// File: rtl/add_round_key_stage_if.sv
// Handshake bundle between the round datapath, the AddRoundKey stage and its consumer.
// The stage itself connects through the slave modport; the producer/consumer side uses master.
interface add_round_key_stage_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         in_first;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic         out_last;

  modport master (
    output in_valid, in_state, in_key, in_first, out_ready,
    input  in_ready, out_valid, out_state, out_round, out_last
  );

  modport slave (
    input  in_valid, in_state, in_key, in_first, out_ready,
    output in_ready, out_valid, out_state, out_round, out_last
  );
endinterface

// File: rtl/add_round_key_stage.sv
// AddRoundKey stage: XORs state with the round key, tags each beat with its round index,
// and buffers the results in a 2-entry in-order FIFO so that every output is registered.
module add_round_key_stage #(
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  add_round_key_stage_if.slave    bus
);
  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   round;
    logic         last;
  } entry_t;

  entry_t       mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic [3:0]   rnd_q;
  logic [3:0]   rnd_d;
  logic         ready_q;
  logic [127:0] xor_data;
  logic [3:0]   tag;
  logic         accept;
  logic         retire;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte_xor
      assign xor_data[8*gi +: 8] = bus.in_state[8*gi +: 8] ^ bus.in_key[8*gi +: 8];
    end
  endgenerate

  assign accept = bus.in_valid & ready_q;
  assign retire = bus.out_ready & (count_q != 2'd0);

  always_comb begin
    tag     = bus.in_first ? 4'd0 : rnd_q;
    rnd_d   = rnd_q;
    count_d = count_q + {1'b0, accept} - {1'b0, retire};
    if (accept) begin
      rnd_d = (tag == 4'(NR)) ? 4'd0 : tag + 4'd1;
    end
  end

  // ready_q mirrors (count < 2) from the next count, so in_ready never sees out_ready
  // combinationally and stays low for the first cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      rnd_q    <= 4'd0;
      ready_q  <= 1'b0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= '{data: xor_data, round: tag, last: (tag == 4'(NR))};
      end
      wr_ptr_q <= wr_ptr_q ^ accept;
      rd_ptr_q <= rd_ptr_q ^ retire;
      count_q  <= count_d;
      rnd_q    <= rnd_d;
      ready_q  <= (count_d != 2'd2);
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_state = mem_q[rd_ptr_q].data;
  assign bus.out_round = mem_q[rd_ptr_q].round;
  assign bus.out_last  = mem_q[rd_ptr_q].last;
endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed bench for add_round_key_stage with a scoreboard of expected FIFO entries;
// outputs are sampled on the falling edge, inputs change just after the rising edge.
module tb_add_round_key_stage;
  localparam int NR = 10;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   r;
    logic         l;
  } exp_t;

  logic clk;
  logic rst;
  add_round_key_stage_if bus ();

  add_round_key_stage #(.NR(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       sb[$];
  logic [3:0] m_rnd;
  int         n_pass;
  int         n_total;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic first, input logic [127:0] s, input logic [127:0] k);
    bus.in_valid = v;
    bus.in_first = first;
    bus.in_state = s;
    bus.in_key   = k;
  endtask

  // One clock cycle: check outputs against the scoreboard, then apply the handshakes.
  task automatic cycle(output bit acc);
    exp_t e;
    logic [3:0] t;
    bit do_pop;
    @(negedge clk);
    chk("out_valid", bus.out_valid, sb.size() != 0);
    chk("in_ready", bus.in_ready, sb.size() < 2);
    if (sb.size() != 0) begin
      chk("out_state", bus.out_state, sb[0].d);
      chk("out_round", bus.out_round, sb[0].r);
      chk("out_last", bus.out_last, sb[0].l);
    end
    do_pop = bus.out_valid && bus.out_ready;
    acc    = bus.in_valid && bus.in_ready;
    if (do_pop && sb.size() != 0) void'(sb.pop_front());
    if (acc) begin
      t     = bus.in_first ? 4'd0 : m_rnd;
      m_rnd = (t == 4'(NR)) ? 4'd0 : t + 4'd1;
      e.d   = bus.in_state ^ bus.in_key;
      e.r   = t;
      e.l   = (t == 4'(NR));
      sb.push_back(e);
      $display("beat accepted: round %0d last %0b data %h", e.r, e.l, e.d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    drive(1'b0, 1'b0, '0, '0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6 && sb.size() != 0; i++) cycle(acc);
    chk("drained", sb.size(), 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    bit           acc;
    int           idx;
    logic [127:0] bp_s [3];
    logic [127:0] bp_k [3];

    n_pass = 0;
    n_total = 0;
    m_rnd = 4'd0;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_state", bus.out_state, '0);
    chk("rst_out_round", bus.out_round, 4'd0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready_low", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst_in_ready_high", bus.in_ready, 1'b1);

    // Single known-answer beat
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b1, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
    cycle(acc);
    chk("kat_accept", acc, 1'b1);
    drive(1'b0, 1'b0, '0, '0);
    #1;
    chk("kat_out_valid", bus.out_valid, 1'b1);
    chk("kat_out_state", bus.out_state, 128'h00102030405060708090a0b0c0d0e0f0);
    chk("kat_out_round", bus.out_round, 4'd0);
    chk("kat_out_last", bus.out_last, 1'b0);
    drain();

    // Full block of 11 beats followed by one more beat that must wrap to round 0
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, i == 0, rnd128(), rnd128());
      cycle(acc);
      chk("block_accept", acc, 1'b1);
      if (i == 10) chk("block_wrap_rnd", m_rnd, 4'd0);
    end
    drain();

    // Backpressure: three beats offered with the consumer stalled
    for (int i = 0; i < 3; i++) begin
      bp_s[i] = rnd128();
      bp_k[i] = rnd128();
    end
    bus.out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, bp_s[idx], bp_k[idx]);
      cycle(acc);
      if (acc) idx++;
    end
    chk("bp_accepted_two", idx, 2);
    chk("bp_in_ready_low", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12 && !(idx == 3 && sb.size() == 0); i++) begin
      if (idx < 3) drive(1'b1, 1'b0, bp_s[idx], bp_k[idx]);
      else drive(1'b0, 1'b0, '0, '0);
      cycle(acc);
      if (acc) idx++;
    end
    chk("bp_third_accepted", idx, 3);
    chk("bp_drained", sb.size(), 0);

    // Simultaneous accept and retire at count 1
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, rnd128(), rnd128());
    cycle(acc);
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, 128'h0123456789abcdef0011223344556677, 128'h0);
    cycle(acc);
    chk("sim_accept", acc, 1'b1);
    drive(1'b0, 1'b0, '0, '0);
    #1;
    chk("sim_out_valid", bus.out_valid, 1'b1);
    chk("sim_out_state", bus.out_state, 128'h0123456789abcdef0011223344556677);
    chk("sim_out_round", bus.out_round, 4'd1);
    drain();

    // Restart on the fifth beat of a block
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i == 0) || (i == 4), rnd128(), rnd128());
      cycle(acc);
      if (i == 4) chk("restart_rnd", m_rnd, 4'd1);
    end
    drain();

    // Asynchronous reset with the FIFO full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, i == 0, rnd128(), rnd128());
      cycle(acc);
    end
    drive(1'b0, 1'b0, '0, '0);
    chk("full_before_rst", bus.in_ready, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_out_state", bus.out_state, '0);
    chk("arst_out_round", bus.out_round, 4'd0);
    chk("arst_in_ready", bus.in_ready, 1'b0);
    sb.delete();
    m_rnd = 4'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_release_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, rnd128(), rnd128());
    cycle(acc);
    drive(1'b0, 1'b0, '0, '0);
    #1;
    chk("arst_first_round", bus.out_round, 4'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
